max_tracker: RTL

MAX_TRACKER -- requirements
Module: max_tracker

---
 rtl/max_tracker.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/max_tracker.sv
// Streaming arg-max tracker.
// Each accepted beat carries NUM_LANES (score, row, col) candidates plus a lane
// mask. Stage 1 reduces the unmasked lanes of a beat to a single tuple; stage 2
// folds that tuple into the running frame maximum. A frame is opened by start,
// closed by an accepted beat with in_last, and its result is held in DONE until
// the consumer handshakes it away. Results stay visible until the next start.
module max_tracker #(
  localparam int SCORE_WIDTH    = 16,
  localparam int ROW_BITS_WIDTH = 12,
  localparam int COL_BITS_WIDTH = 12,
  parameter int NUM_LANES = 16,
  parameter int SCORE_W   = SCORE_WIDTH,
  parameter int ROW_W     = ROW_BITS_WIDTH,
  parameter int COL_W     = COL_BITS_WIDTH,
  parameter int CNT_W     = 8,
  parameter int TIE_LAST  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [NUM_LANES-1:0]               lane_mask,
  input  logic [NUM_LANES-1:0][SCORE_W-1:0]  score_in,
  input  logic [NUM_LANES-1:0][ROW_W-1:0]    row_in,
  input  logic [NUM_LANES-1:0][COL_W-1:0]    col_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SCORE_W-1:0]                 max_score,
  output logic [ROW_W-1:0]                   max_row,
  output logic [COL_W-1:0]                   max_col,
  output logic                               max_found,
  output logic [CNT_W-1:0]                   beat_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;

  // Stage-1 combinational reduction result
  logic               red_any;
  logic [SCORE_W-1:0] red_score;
  logic [ROW_W-1:0]   red_row;
  logic [COL_W-1:0]   red_col;

  // Stage-1 registered tuple
  logic               s1_valid_q;
  logic               s1_any_q;
  logic [SCORE_W-1:0] s1_score_q;
  logic [ROW_W-1:0]   s1_row_q;
  logic [COL_W-1:0]   s1_col_q;

  // Running frame result
  logic [SCORE_W-1:0] max_score_q;
  logic [ROW_W-1:0]   max_row_q;
  logic [COL_W-1:0]   max_col_q;
  logic               max_found_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  // Candidates are always visited in arrival order, so strict-greater keeps the
  // earliest of equal scores and greater-or-equal lets the latest replace it.
  function automatic logic wins(input logic [SCORE_W-1:0] cand,
                                input logic [SCORE_W-1:0] cur);
    if (TIE_LAST != 0) return cand >= cur;
    else               return cand >  cur;
  endfunction

  assign accept = in_valid & in_ready_q;

  // Reduce the unmasked lanes of the current beat, lowest lane first.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    red_any   = 1'b0;
    red_score = '0;
    red_row   = '0;
    red_col   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_mask[i] && (!red_any || wins(score_in[i], red_score))) begin
        red_any   = 1'b1;
        red_score = score_in[i];
        red_row   = row_in[i];
        red_col   = col_in[i];
      end
    end
  end

  // Frame control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the per-beat reduction at the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_score_q <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_any_q   <= red_any;
        s1_score_q <= red_score;
        s1_row_q   <= red_row;
        s1_col_q   <= red_col;
      end
    end
  end

  // Stage 2: merge the registered tuple into the running max; count beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score_q <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
      max_found_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else if (state_q == IDLE && start) begin
      max_score_q <= '0;
      max_row_q   <= '0;
      max_col_q   <= '0;
      max_found_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      // The first valid candidate of a frame always loads, even a zero score.
      if (s1_valid_q && s1_any_q && (!max_found_q || wins(s1_score_q, max_score_q))) begin
        max_score_q <= s1_score_q;
        max_row_q   <= s1_row_q;
        max_col_q   <= s1_col_q;
        max_found_q <= 1'b1;
      end
      if (accept && (beat_cnt_q != {CNT_W{1'b1}})) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign max_score = max_score_q;
  assign max_row   = max_row_q;
  assign max_col   = max_col_q;
  assign max_found = max_found_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
